// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    localparam logic [5:0] PRESCALE_4  = 6'd4;
    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic prescale_legal(input logic [5:0] prescale);
        return (prescale == PRESCALE_4)  || (prescale == PRESCALE_8) ||
               (prescale == PRESCALE_16) || (prescale == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_edge_bit_counter.sv
// Oversampling edge counter and bit counter; both clear whenever enable is low.
module edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int BIT_CW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [5:0]        prescale,
    output logic [4:0]        edge_count,
    output logic [BIT_CW-1:0] bit_count,
    output logic              bit_end
);

    assign bit_end = enable && ({1'b0, edge_count} == (prescale - 6'd1));

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (bit_end) begin
            edge_count <= '0;
            bit_count  <= bit_count + BIT_CW'(1);
        end else begin
            edge_count <= edge_count + 5'd1;
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART Rx frame controller: start detect, deserialisation, parity/stop checks.
// Optional break detection is built when UART_RX_BREAK_DETECT_EN is defined.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [4:0]            edge_count,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  brk_det
);

    localparam int BIT_CW = $clog2(DATA_WIDTH + 4);

    state_t                state;
    logic [DATA_WIDTH-1:0] shift;
    logic [BIT_CW-1:0]     bit_count;
    logic                  bit_end;
    logic                  legal;
    logic                  cnt_en;

    assign legal = prescale_legal(Prescale);
    // Gating with legal clears the counters on the same edge that an abort happens.
    assign cnt_en = dat_samp_en && legal;

    edge_bit_counter #(.BIT_CW(BIT_CW)) u_counter (
        .clk        (CLK),
        .rst_n      (RST),
        .enable     (cnt_en),
        .prescale   (Prescale),
        .edge_count (edge_count),
        .bit_count  (bit_count),
        .bit_end    (bit_end)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= IDLE;
            dat_samp_en <= 1'b0;
            shift       <= '0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (state != IDLE && !legal) begin
                state       <= IDLE;
                dat_samp_en <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!RX_IN && legal) begin
                            state       <= START;
                            dat_samp_en <= 1'b1;
                            par_err     <= 1'b0;
                            stp_err     <= 1'b0;
                        end
                    end
                    START: begin
                        if (bit_end) begin
                            if (sampled_bit) begin
                                state       <= IDLE;
                                dat_samp_en <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            shift <= {sampled_bit, shift[DATA_WIDTH-1:1]};
                            if (bit_count == BIT_CW'(DATA_WIDTH)) begin
                                state <= PAR_EN ? PARITY : STOP;
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            par_err <= ((^shift) ^ (PAR_TYP == PAR_ODD)) != sampled_bit;
                            state   <= STOP;
                        end
                    end
                    STOP: begin
                        // Outputs land on entry to DONE so they are visible exactly in that cycle.
                        if (bit_end) begin
                            stp_err     <= !sampled_bit;
                            dat_samp_en <= 1'b0;
                            state       <= DONE;
                            if (sampled_bit && !par_err) begin
                                P_DATA     <= shift;
                                data_valid <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state       <= IDLE;
                        dat_samp_en <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic line_zero;

    // line_zero tracks whether every bit after the start bit has been 0 so far.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            line_zero <= 1'b0;
            brk_det   <= 1'b0;
        end else begin
            brk_det <= 1'b0;
            if (state == IDLE) begin
                line_zero <= 1'b1;
            end else if (bit_end && state != START && sampled_bit) begin
                line_zero <= 1'b0;
            end
            if (state == STOP && bit_end && legal && !sampled_bit && line_zero) begin
                brk_det <= 1'b1;
            end
        end
    end
`else
    assign brk_det = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl; break expectation follows UART_RX_BREAK_DETECT_EN.
module tb_uart_rx_frame_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic       dat_samp_en;
    logic [4:0] edge_count;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       brk_det;

    typedef struct {
        logic [7:0] data;
        int         frame_len;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   start_cyc  = 0;
    int   brk_pulses = 0;
    logic prev_samp  = 1'b0;
    logic seen_en;

`ifdef UART_RX_BREAK_DETECT_EN
    localparam int BRK_EXP = 1;
`else
    localparam int BRK_EXP = 0;
`endif

    uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .sampled_bit (sampled_bit),
        .dat_samp_en (dat_samp_en),
        .edge_count  (edge_count),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .brk_det     (brk_det)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every data_valid pulse.
    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            if (dat_samp_en && !prev_samp) start_cyc = cyc;
            if (brk_det) brk_pulses++;
            if (data_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_valid: got data_valid with P_DATA=%0h, required none", P_DATA);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("p_data", P_DATA, e.data);
                    checkOutput("frame_len", cyc - start_cyc + 1, e.frame_len);
                end
            end
        end
        prev_samp = dat_samp_en;
    end

    task automatic driveBit(input logic b, input logic [5:0] p);
        RX_IN       = b;
        sampled_bit = b;
        repeat (p) @(negedge CLK);
    endtask

    // Sends one frame; returns at the negedge inside the DONE cycle with the line idle.
    task automatic applyStimulus(input logic [5:0] p, input logic pe, input logic pt,
                                 input logic [7:0] data, input logic par_bit, input logic stop_bit);
        Prescale    = p;
        PAR_EN      = pe;
        PAR_TYP     = pt;
        RX_IN       = 1'b1;
        sampled_bit = 1'b1;
        @(negedge CLK);
        RX_IN       = 1'b0;
        sampled_bit = 1'b0;
        @(negedge CLK);
        driveBit(1'b0, p);
        for (int i = 0; i < 8; i++) driveBit(data[i], p);
        if (pe) driveBit(par_bit, p);
        driveBit(stop_bit, p);
        RX_IN       = 1'b1;
        sampled_bit = 1'b1;
    endtask

    task automatic checkAfterFrame(input logic exp_par, input logic exp_stp,
                                   input logic [7:0] exp_data, input int exp_brk);
        @(negedge CLK);
        checkOutput("valid_pulse_width", data_valid, 1'b0);
        checkOutput("samp_en_idle", dat_samp_en, 1'b0);
        checkOutput("par_err", par_err, exp_par);
        checkOutput("stp_err", stp_err, exp_stp);
        checkOutput("p_data_hold", P_DATA, exp_data);
        checkOutput("brk_pulses", brk_pulses, exp_brk);
    endtask

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        RST         = 1'b0;
        RX_IN       = 1'b1;
        sampled_bit = 1'b1;
        Prescale    = 6'd8;
        PAR_EN      = 1'b0;
        PAR_TYP     = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("rst_samp_en", dat_samp_en, 1'b0);
        checkOutput("rst_edge_count", edge_count, 5'd0);
        checkOutput("rst_p_data", P_DATA, 8'h00);
        checkOutput("rst_valid", data_valid, 1'b0);
        checkOutput("rst_par_err", par_err, 1'b0);
        checkOutput("rst_stp_err", stp_err, 1'b0);
        checkOutput("rst_brk", brk_det, 1'b0);
        RST = 1'b1;
        @(negedge CLK);

        $display("[TB] good frame 0xA5, prescale 8, even parity");
        exp_q.push_back('{data: 8'hA5, frame_len: 89});
        brk_pulses = 0;
        applyStimulus(6'd8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1);
        checkAfterFrame(1'b0, 1'b0, 8'hA5, 0);

        $display("[TB] parity error 0x3C, prescale 16, odd parity");
        brk_pulses = 0;
        applyStimulus(6'd16, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1);
        checkAfterFrame(1'b1, 1'b0, 8'hA5, 0);

        $display("[TB] stop error 0xFF, prescale 4");
        brk_pulses = 0;
        applyStimulus(6'd4, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
        checkAfterFrame(1'b0, 1'b1, 8'hA5, 0);

        $display("[TB] break frame 0x00 with stop 0, prescale 4");
        brk_pulses = 0;
        applyStimulus(6'd4, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkAfterFrame(1'b0, 1'b1, 8'hA5, BRK_EXP);

        $display("[TB] false start, prescale 8");
        Prescale    = 6'd8;
        RX_IN       = 1'b0;
        sampled_bit = 1'b1;
        @(negedge CLK);
        checkOutput("false_start_en", dat_samp_en, 1'b1);
        @(negedge CLK);
        RX_IN = 1'b1;
        repeat (6) @(negedge CLK);
        checkOutput("false_start_last_edge", edge_count, 5'd7);
        checkOutput("false_start_en_held", dat_samp_en, 1'b1);
        @(negedge CLK);
        checkOutput("false_start_back_idle", dat_samp_en, 1'b0);
        checkOutput("false_start_edge_clr", edge_count, 5'd0);
        checkOutput("false_start_par", par_err, 1'b0);
        checkOutput("false_start_stp", stp_err, 1'b0);

        $display("[TB] back-to-back 0x12 and 0x34, prescale 32");
        exp_q.push_back('{data: 8'h12, frame_len: 353});
        exp_q.push_back('{data: 8'h34, frame_len: 353});
        brk_pulses = 0;
        applyStimulus(6'd32, 1'b1, 1'b0, 8'h12, 1'b0, 1'b1);
        applyStimulus(6'd32, 1'b1, 1'b0, 8'h34, 1'b1, 1'b1);
        checkAfterFrame(1'b0, 1'b0, 8'h34, 0);

        $display("[TB] illegal prescale 6 from idle");
        Prescale    = 6'd6;
        RX_IN       = 1'b0;
        sampled_bit = 1'b0;
        seen_en     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            seen_en = seen_en | dat_samp_en;
        end
        checkOutput("illegal_idle_en", seen_en, 1'b0);
        checkOutput("illegal_idle_edge", edge_count, 5'd0);
        RX_IN       = 1'b1;
        sampled_bit = 1'b1;
        Prescale    = 6'd8;
        @(negedge CLK);

        $display("[TB] illegal prescale mid-frame");
        RX_IN       = 1'b0;
        sampled_bit = 1'b0;
        repeat (20) @(negedge CLK);
        checkOutput("mid_frame_active", dat_samp_en, 1'b1);
        Prescale = 6'd5;
        @(negedge CLK);
        checkOutput("abort_en", dat_samp_en, 1'b0);
        checkOutput("abort_edge", edge_count, 5'd0);
        checkOutput("abort_valid", data_valid, 1'b0);
        Prescale    = 6'd8;
        RX_IN       = 1'b1;
        sampled_bit = 1'b1;
        repeat (2) @(negedge CLK);
        checkOutput("abort_stays_idle", dat_samp_en, 1'b0);

        $display("[TB] reset mid-data");
        RX_IN       = 1'b0;
        sampled_bit = 1'b0;
        repeat (30) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("mid_rst_en", dat_samp_en, 1'b0);
        checkOutput("mid_rst_edge", edge_count, 5'd0);
        checkOutput("mid_rst_p_data", P_DATA, 8'h00);
        checkOutput("mid_rst_valid", data_valid, 1'b0);
        checkOutput("mid_rst_flags", {par_err, stp_err, brk_det}, 3'b000);
        RST         = 1'b1;
        RX_IN       = 1'b1;
        sampled_bit = 1'b1;
        @(negedge CLK);

        $display("[TB] recovery frame 0x5A, prescale 16, no parity");
        exp_q.push_back('{data: 8'h5A, frame_len: 161});
        brk_pulses = 0;
        applyStimulus(6'd16, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1);
        checkAfterFrame(1'b0, 1'b0, 8'h5A, 0);

        repeat (4) @(negedge CLK);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
